// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types plus register-file defaults.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0] regbits_t;
  localparam int RF_NREGS = 32;
  localparam int RF_WIDTH = 32;
  localparam int RF_NREAD = 2;
  localparam int RF_NWRITE = 2;
  localparam int RF_ZERO_REG = 1;
  typedef logic [RF_NREGS-1:0] busy_t;
endpackage

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: bundle for register_file_mp with rf and tb modports.
interface register_file_mp_if import cpu_types_pkg::*; #(
  parameter int NREGS = RF_NREGS,
  parameter int WIDTH = RF_WIDTH,
  parameter int NREAD = RF_NREAD,
  parameter int NWRITE = RF_NWRITE,
  localparam int AW = $clog2(NREGS)
) (
  input logic CLK,
  input logic RST
);
  logic [NWRITE-1:0] wen;
  logic [NWRITE*AW-1:0] wsel;
  logic [NWRITE*WIDTH-1:0] wdat;
  logic [NREAD*AW-1:0] rsel;
  logic [NREAD*WIDTH-1:0] rdat;
  logic [NREAD-1:0] rbusy;
  logic issue_en;
  logic [AW-1:0] issue_sel;
  logic issue_waw;
  logic [NREGS-1:0] busy_vec;
  modport rf (input CLK, RST, wen, wsel, wdat, rsel, issue_en, issue_sel,
              output rdat, rbusy, issue_waw, busy_vec);
  modport tb (input CLK, RST, rdat, rbusy, issue_waw, busy_vec,
              output wen, wsel, wdat, rsel, issue_en, issue_sel);
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits; issue sets, writeback clears, issue wins.
module rf_scoreboard import cpu_types_pkg::*; #(
  parameter int NREGS = RF_NREGS,
  parameter int NWRITE = RF_NWRITE,
  parameter int ZERO_REG = RF_ZERO_REG,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NWRITE-1:0]    wen,
  input  logic [NWRITE*AW-1:0] wsel,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_sel,
  output logic                 issue_waw,
  output logic [NREGS-1:0]     busy_vec
);
  logic [NREGS-1:0] clr, set, busy_nxt;
  always_comb begin
    clr = '0;
    set = '0;
    for (int k = 0; k < NWRITE; k++)
      if (wen[k]) clr[wsel[k*AW +: AW]] = 1'b1;
    if (issue_en && !(ZERO_REG != 0 && issue_sel == '0)) set[issue_sel] = 1'b1;
    busy_nxt = set | (busy_vec & ~clr);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) busy_vec <= '0;
    else busy_vec <= busy_nxt;
  assign issue_waw = issue_en && busy_vec[issue_sel];
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: NREAD-read / NWRITE-write register file with busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module register_file_mp import cpu_types_pkg::*; #(
  parameter int NREGS = RF_NREGS,
  parameter int WIDTH = RF_WIDTH,
  parameter int NREAD = RF_NREAD,
  parameter int NWRITE = RF_NWRITE,
  parameter int ZERO_REG = RF_ZERO_REG,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NWRITE-1:0]       wen,
  input  logic [NWRITE*AW-1:0]    wsel,
  input  logic [NWRITE*WIDTH-1:0] wdat,
  input  logic [NREAD*AW-1:0]     rsel,
  output logic [NREAD*WIDTH-1:0]  rdat,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    issue_en,
  input  logic [AW-1:0]           issue_sel,
  output logic                    issue_waw,
  output logic [NREGS-1:0]        busy_vec
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0] s;
  rf_scoreboard #(.NREGS(NREGS), .NWRITE(NWRITE), .ZERO_REG(ZERO_REG)) u_sb (
    .CLK(CLK), .RST(RST), .wen(wen), .wsel(wsel), .issue_en(issue_en),
    .issue_sel(issue_sel), .issue_waw(issue_waw), .busy_vec(busy_vec)
  );
  // Ascending port order makes the highest-index port win a same-address collision.
  always_ff @(posedge CLK or posedge RST)
    if (RST) for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    else
      for (int k = 0; k < NWRITE; k++)
        if (wen[k] && !(ZERO_REG != 0 && wsel[k*AW +: AW] == '0))
          regs[wsel[k*AW +: AW]] <= wdat[k*WIDTH +: WIDTH];
  always_comb begin
    rdat = '0;
    rbusy = '0;
    s = '0;
    for (int i = 0; i < NREAD; i++) begin
      s = rsel[i*AW +: AW];
      rdat[i*WIDTH +: WIDTH] = (ZERO_REG != 0 && s == '0) ? '0 : regs[s];
      rbusy[i] = busy_vec[s];
`ifdef RF_BYPASS_EN
      for (int k = 0; k < NWRITE; k++)
        if (wen[k] && wsel[k*AW +: AW] == s && !(ZERO_REG != 0 && s == '0)) begin
          rdat[i*WIDTH +: WIDTH] = wdat[k*WIDTH +: WIDTH];
          rbusy[i] = issue_en && issue_sel == s && busy_vec[s];
        end
`endif
    end
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed and randomized checks against an array-based reference model.
module tb_register_file_mp;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic RST;
  logic [1:0] wen;
  logic [9:0] wsel;
  logic [63:0] wdat;
  logic [9:0] rsel;
  logic [63:0] rdat;
  logic [1:0] rbusy;
  logic issue_en;
  logic [4:0] issue_sel;
  logic issue_waw;
  logic [31:0] busy_vec;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] mreg [32];
  logic [31:0] mbusy;

  register_file_mp dut (
    .CLK(CLK), .RST(RST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
    .rdat(rdat), .rbusy(rbusy), .issue_en(issue_en), .issue_sel(issue_sel),
    .issue_waw(issue_waw), .busy_vec(busy_vec)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_rd(input logic [4:0] r);
    logic [31:0] v;
    if (r == 5'd0) return 32'd0;
    v = mreg[r];
`ifdef RF_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (wen[k] && wsel[k*5 +: 5] == r) v = wdat[k*32 +: 32];
`endif
    return v;
  endfunction

  function automatic logic exp_rb(input logic [4:0] r);
    logic b;
    b = mbusy[r];
`ifdef RF_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (wen[k] && wsel[k*5 +: 5] == r && !(issue_en && issue_sel == r)) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mreg[r] = 32'd0;
    mbusy = 32'd0;
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] s0, input logic [31:0] d0,
                       input logic [4:0] s1, input logic [31:0] d1,
                       input logic ie, input logic [4:0] is);
    wen = w;
    wsel = {s1, s0};
    wdat = {d1, d0};
    issue_en = ie;
    issue_sel = is;
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RST) begin
      for (int k = 0; k < 2; k++)
        if (wen[k] && wsel[k*5 +: 5] != 5'd0) mreg[wsel[k*5 +: 5]] = wdat[k*32 +: 32];
      for (int k = 0; k < 2; k++)
        if (wen[k]) mbusy[wsel[k*5 +: 5]] = 1'b0;
      if (issue_en && issue_sel != 5'd0) mbusy[issue_sel] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle();
    issue_en = 1'b1;
    issue_sel = 5'd4;
    rsel = {5'd9, 5'd5};
    model_reset();
    #2;
    n_cmp++; if (rdat !== 64'd0) begin n_fail++; $display("FAIL reset_rdat: got %h expected 0", rdat); end
    n_cmp++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL reset_rbusy: got %b expected 00", rbusy); end
    n_cmp++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL reset_busy_vec: got %h expected 0", busy_vec); end
    n_cmp++; if (issue_waw !== 1'b0) begin n_fail++; $display("FAIL reset_waw: got %b expected 0", issue_waw); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b1, 5'd5);
    tick();
    idle();
    rsel = {5'd0, 5'd5};
    #1;
    n_cmp++; if (rdat[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset_rdat: got %h expected deadbeef", rdat[31:0]); end
    n_cmp++; if (busy_vec[5] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy5: got %b expected 1", busy_vec[5]); end
    #2;
    drive(2'b01, 5'd5, 32'h1, 5'd0, 32'd0, 1'b1, 5'd6);
    RST = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (rdat[31:0] !== 32'd0) begin n_fail++; $display("FAIL async_reset_rdat: got %h expected 0", rdat[31:0]); end
    n_cmp++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL async_reset_busy_vec: got %h expected 0", busy_vec); end
    tick();
    n_cmp++; if (rdat[31:0] !== 32'd0 || busy_vec !== 32'd0) begin n_fail++; $display("FAIL reset_write_lost: got %h/%h expected 0/0", rdat[31:0], busy_vec); end
    RST = 1'b0;
    idle();
  endtask

  task automatic test_collision();
    drive(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0);
    tick();
    idle();
    rsel = {5'd7, 5'd7};
    #1;
    n_cmp++; if (rdat[31:0] !== 32'h22) begin n_fail++; $display("FAIL collision_p0: got %h expected 22", rdat[31:0]); end
    n_cmp++; if (rdat[63:32] !== 32'h22) begin n_fail++; $display("FAIL collision_p1: got %h expected 22", rdat[63:32]); end
  endtask

  task automatic test_zero_reg();
    drive(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0);
    tick();
    idle();
    rsel = {5'd0, 5'd0};
    #1;
    n_cmp++; if (rdat !== 64'd0) begin n_fail++; $display("FAIL zero_rdat: got %h expected 0", rdat); end
    n_cmp++; if (busy_vec[0] !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy_vec[0]); end
  endtask

  task automatic test_scoreboard_seq();
    rsel = {5'd0, 5'd3};
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3);
    tick();
    idle();
    #1;
    n_cmp++; if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_busy_c1: got %b expected 1", rbusy[0]); end
    tick();
    drive(2'b10, 5'd0, 32'd0, 5'd3, 32'hA5, 1'b0, 5'd0);
    tick();
    idle();
    #1;
    n_cmp++; if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_busy_c3: got %b expected 0", rbusy[0]); end
    n_cmp++; if (rdat[31:0] !== 32'hA5) begin n_fail++; $display("FAIL sb_rdat_c3: got %h expected a5", rdat[31:0]); end
    drive(2'b01, 5'd3, 32'h5A, 5'd0, 32'd0, 1'b1, 5'd3);
    tick();
    idle();
    #1;
    n_cmp++; if (busy_vec[3] !== 1'b1) begin n_fail++; $display("FAIL sb_busy_c4: got %b expected 1", busy_vec[3]); end
    n_cmp++; if (rdat[31:0] !== 32'h5A) begin n_fail++; $display("FAIL sb_rdat_c4: got %h expected 5a", rdat[31:0]); end
  endtask

  task automatic test_waw();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9);
    #1;
    n_cmp++; if (issue_waw !== 1'b0) begin n_fail++; $display("FAIL waw_first: got %b expected 0", issue_waw); end
    tick();
    #1;
    n_cmp++; if (issue_waw !== 1'b1) begin n_fail++; $display("FAIL waw_second: got %b expected 1", issue_waw); end
    tick();
    idle();
    #1;
    n_cmp++; if (issue_waw !== 1'b0) begin n_fail++; $display("FAIL waw_after: got %b expected 0", issue_waw); end
    n_cmp++; if (busy_vec[9] !== 1'b1) begin n_fail++; $display("FAIL waw_busy9: got %b expected 1", busy_vec[9]); end
  endtask

  task automatic test_bypass();
    drive(2'b01, 5'd12, 32'h0BAD, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    rsel = {5'd12, 5'd0};
    drive(2'b01, 5'd12, 32'h1234, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
`ifdef RF_BYPASS_EN
    n_cmp++; if (rdat[63:32] !== 32'h1234) begin n_fail++; $display("FAIL bypass_same: got %h expected 1234", rdat[63:32]); end
`else
    n_cmp++; if (rdat[63:32] !== 32'h0BAD) begin n_fail++; $display("FAIL bypass_same: got %h expected 0bad", rdat[63:32]); end
`endif
    tick();
    idle();
    #1;
    n_cmp++; if (rdat[63:32] !== 32'h1234) begin n_fail++; $display("FAIL bypass_next: got %h expected 1234", rdat[63:32]); end
  endtask

  task automatic test_random();
    logic [4:0] r;
    for (int c = 0; c < 400; c++) begin
      drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)));
      rsel = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #2;
      for (int i = 0; i < 2; i++) begin
        r = rsel[i*5 +: 5];
        n_cmp++;
        if (rdat[i*32 +: 32] !== exp_rd(r)) begin
          n_fail++; $display("FAIL rand_rdat%0d c%0d reg%0d: got %h expected %h", i, c, r, rdat[i*32 +: 32], exp_rd(r));
        end
        n_cmp++;
        if (rbusy[i] !== exp_rb(r)) begin
          n_fail++; $display("FAIL rand_rbusy%0d c%0d reg%0d: got %b expected %b", i, c, r, rbusy[i], exp_rb(r));
        end
      end
      n_cmp++;
      if (issue_waw !== (issue_en && mbusy[issue_sel])) begin
        n_fail++; $display("FAIL rand_waw c%0d: got %b expected %b", c, issue_waw, issue_en && mbusy[issue_sel]);
      end
      n_cmp++;
      if (busy_vec !== mbusy) begin
        n_fail++; $display("FAIL rand_busy_vec c%0d: got %h expected %h", c, busy_vec, mbusy);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_collision();
    test_zero_reg();
    test_scoreboard_seq();
    test_waw();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
